cache_fill_ctrl: RTL and testbench

//  Sequencer for the 8-way instruction/data cache, sitting upstream of CacheDataMux.

---
 rtl/cache_fill_ctrl.sv | 88 ++++++++
 tb/tb_cache_fill_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Cache fill sequencer: lookup, round-robin victim fill over a req/ack memory port, re-lookup.
// Optional fill watchdog enabled by defining CACHE_TIMEOUT_EN.
module cache_fill_ctrl #(
  parameter int WAYS     = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 23,
  parameter int WAIT_MAX = 255
) (
  input  logic              Clock,
  input  logic              Reset_H,
  input  logic              CpuReq_H,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [WAYS-1:0]   ValidHit_H,
  output logic              CpuAck_H,
  output logic              MemReq_H,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck_H,
  input  logic [DATA_W-1:0] MemData,
  output logic [WAYS-1:0]   WayWrite_H,
  output logic [DATA_W-1:0] FillData,
  output logic              Busy_H,
  output logic              BusErr_H
);

  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [VW-1:0] victim;
  logic          timeout;

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state    <= IDLE;
      victim   <= '0;
      MemAddr  <= '0;
      FillData <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && CpuReq_H)
        MemAddr <= CpuAddr;
      if (state == FILL && MemAck_H)
        FillData <= MemData;
      if (state == WRITE)
        victim <= (victim == VW'(WAYS-1)) ? '0 : victim + 1'b1;
    end
  end

`ifdef CACHE_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_MAX+1);
  logic [CW-1:0] wdog;

  // Held at zero outside FILL, so it is clear on every entry to FILL.
  always_ff @(posedge Clock) begin
    if (Reset_H || state != FILL) wdog <= '0;
    else                          wdog <= wdog + 1'b1;
  end

  assign timeout = (state == FILL) && (wdog == CW'(WAIT_MAX-1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CpuReq_H) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = (|ValidHit_H) ? DONE : FILL;
      FILL: begin
        // A same-cycle ack wins over the watchdog.
        if (MemAck_H)     state_nxt = WRITE;
        else if (timeout) state_nxt = ERR;
      end
      WRITE:   state_nxt = CpuReq_H ? LOOKUP : IDLE;
      DONE:    if (!CpuReq_H) state_nxt = IDLE;
      ERR:     if (!CpuReq_H) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign CpuAck_H   = (state == DONE);
  assign MemReq_H   = (state == FILL);
  assign Busy_H     = (state != IDLE);
  assign BusErr_H   = (state == ERR);
  assign WayWrite_H = (state == WRITE) ? ({{(WAYS-1){1'b0}}, 1'b1} << victim) : '0;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: vector table for hit/miss flow, hand sequences for corners.
module tb_cache_fill_ctrl;

  logic        Clock = 0;
  logic        Reset_H, CpuReq_H, MemAck_H;
  logic [22:0] CpuAddr;
  logic [7:0]  ValidHit_H;
  logic [15:0] MemData;
  logic        CpuAck_H, MemReq_H, Busy_H, BusErr_H;
  logic [22:0] MemAddr;
  logic [7:0]  WayWrite_H;
  logic [15:0] FillData;

  int checks = 0;
  int errors = 0;

  cache_fill_ctrl #(.WAYS(8), .DATA_W(16), .ADDR_W(23), .WAIT_MAX(16)) dut (
    .Clock(Clock), .Reset_H(Reset_H), .CpuReq_H(CpuReq_H), .CpuAddr(CpuAddr),
    .ValidHit_H(ValidHit_H), .CpuAck_H(CpuAck_H), .MemReq_H(MemReq_H), .MemAddr(MemAddr),
    .MemAck_H(MemAck_H), .MemData(MemData), .WayWrite_H(WayWrite_H), .FillData(FillData),
    .Busy_H(Busy_H), .BusErr_H(BusErr_H)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        req;
    logic [22:0] addr;
    logic [7:0]  hit;
    logic        mack;
    logic [15:0] mdata;
    logic        e_ack;
    logic        e_mreq;
    logic [7:0]  e_ww;
    logic        e_busy;
    logic [22:0] e_maddr;
    logic [15:0] e_fd;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic req, logic [22:0] addr, logic [7:0] hit, logic mack,
                              logic [15:0] mdata, logic e_ack, logic e_mreq, logic [7:0] e_ww,
                              logic e_busy, logic [22:0] e_maddr, logic [15:0] e_fd);
    vec_t v;
    v.req = req; v.addr = addr; v.hit = hit; v.mack = mack; v.mdata = mdata;
    v.e_ack = e_ack; v.e_mreq = e_mreq; v.e_ww = e_ww; v.e_busy = e_busy;
    v.e_maddr = e_maddr; v.e_fd = e_fd;
    return v;
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    Reset_H = 1; CpuReq_H = 0; MemAck_H = 0; ValidHit_H = 0;
    tick; tick;
    Reset_H = 0;
  endtask

  task automatic miss(input logic [7:0] exp_ww, input string nm);
    CpuReq_H = 1; ValidHit_H = 0;
    tick;
    chk({nm, " lookup mreq"}, MemReq_H, 0);
    tick;
    chk({nm, " mreq"}, MemReq_H, 1);
    MemAck_H = 1; MemData = {8'hA5, exp_ww};
    tick;
    MemAck_H = 0;
    chk({nm, " ww"}, WayWrite_H, exp_ww);
    chk({nm, " fd"}, FillData, {8'hA5, exp_ww});
    ValidHit_H = exp_ww;
    tick;
    chk({nm, " ww one cycle"}, WayWrite_H, 0);
    tick;
    chk({nm, " ack"}, CpuAck_H, 1);
    CpuReq_H = 0; ValidHit_H = 0;
    tick;
    chk({nm, " idle"}, Busy_H, 0);
  endtask

  task automatic hit(input string nm);
    CpuReq_H = 1; ValidHit_H = 8'hFF;
    tick;
    chk({nm, " no ww"}, WayWrite_H, 0);
    tick;
    chk({nm, " ack"}, CpuAck_H, 1);
    chk({nm, " mreq"}, MemReq_H, 0);
    CpuReq_H = 0; ValidHit_H = 0;
    tick;
    chk({nm, " idle"}, Busy_H, 0);
  endtask

  initial begin
    logic [7:0] way;
    int         n;
    CpuAddr = 0; MemData = 0;
    do_reset;

    chk("rst ack", CpuAck_H, 0);
    chk("rst mreq", MemReq_H, 0);
    chk("rst ww", WayWrite_H, 0);
    chk("rst busy", Busy_H, 0);
    chk("rst buserr", BusErr_H, 0);
    chk("rst maddr", MemAddr, 0);
    chk("rst fd", FillData, 0);

    // hit then miss with a 3-cycle fill wait
    tbl[0]  = mk(1, 23'h000100, 8'h04, 0, 16'h0,    0, 0, 8'h00, 1, 23'h000100, 16'h0);
    tbl[1]  = mk(1, 23'h000100, 8'h04, 0, 16'h0,    1, 0, 8'h00, 1, 23'h000100, 16'h0);
    tbl[2]  = mk(1, 23'h000100, 8'h04, 0, 16'h0,    1, 0, 8'h00, 1, 23'h000100, 16'h0);
    tbl[3]  = mk(0, 23'h000100, 8'h00, 0, 16'h0,    0, 0, 8'h00, 0, 23'h000100, 16'h0);
    tbl[4]  = mk(1, 23'h012345, 8'h00, 0, 16'h0,    0, 0, 8'h00, 1, 23'h012345, 16'h0);
    tbl[5]  = mk(1, 23'h012345, 8'h00, 0, 16'h0,    0, 1, 8'h00, 1, 23'h012345, 16'h0);
    tbl[6]  = mk(1, 23'h012345, 8'h00, 0, 16'h0,    0, 1, 8'h00, 1, 23'h012345, 16'h0);
    tbl[7]  = mk(1, 23'h012345, 8'h00, 0, 16'h0,    0, 1, 8'h00, 1, 23'h012345, 16'h0);
    tbl[8]  = mk(1, 23'h012345, 8'h00, 1, 16'hBEEF, 0, 0, 8'h01, 1, 23'h012345, 16'hBEEF);
    tbl[9]  = mk(1, 23'h012345, 8'h01, 0, 16'h0,    0, 0, 8'h00, 1, 23'h012345, 16'hBEEF);
    tbl[10] = mk(1, 23'h012345, 8'h01, 0, 16'h0,    1, 0, 8'h00, 1, 23'h012345, 16'hBEEF);
    tbl[11] = mk(0, 23'h012345, 8'h00, 0, 16'h0,    0, 0, 8'h00, 0, 23'h012345, 16'hBEEF);

    for (int i = 0; i < 12; i++) begin
      CpuReq_H = tbl[i].req; CpuAddr = tbl[i].addr; ValidHit_H = tbl[i].hit;
      MemAck_H = tbl[i].mack; MemData = tbl[i].mdata;
      tick;
      chk($sformatf("vec%0d ack", i),   CpuAck_H,   tbl[i].e_ack);
      chk($sformatf("vec%0d mreq", i),  MemReq_H,   tbl[i].e_mreq);
      chk($sformatf("vec%0d ww", i),    WayWrite_H, tbl[i].e_ww);
      chk($sformatf("vec%0d busy", i),  Busy_H,     tbl[i].e_busy);
      chk($sformatf("vec%0d maddr", i), MemAddr,    tbl[i].e_maddr);
      chk($sformatf("vec%0d fd", i),    FillData,   tbl[i].e_fd);
    end
    MemAck_H = 0;

    // victim wrap with interleaved hits
    do_reset;
    way = 8'h01;
    for (int i = 0; i < 9; i++) begin
      miss(way, $sformatf("wrap%0d", i));
      hit($sformatf("wraphit%0d", i));
      way = {way[6:0], way[7]};
    end

    // reset during FILL, then a stray ack
    CpuReq_H = 1; ValidHit_H = 0;
    tick; tick;
    chk("rstfill mreq before", MemReq_H, 1);
    Reset_H = 1;
    tick;
    chk("rstfill mreq", MemReq_H, 0);
    chk("rstfill busy", Busy_H, 0);
    Reset_H = 0; CpuReq_H = 0;
    tick;
    MemAck_H = 1; MemData = 16'hDEAD;
    tick;
    MemAck_H = 0;
    chk("stray ack ww", WayWrite_H, 0);
    chk("stray ack busy", Busy_H, 0);
    tick;
    chk("stray ack ww late", WayWrite_H, 0);
    miss(8'h01, "post-rst");

    // request abandoned during FILL
    CpuReq_H = 1; ValidHit_H = 0;
    tick; tick;
    chk("abandon mreq", MemReq_H, 1);
    CpuReq_H = 0;
    tick; tick;
    chk("abandon still filling", MemReq_H, 1);
    MemAck_H = 1; MemData = 16'h5A5A;
    tick;
    MemAck_H = 0;
    chk("abandon ww", WayWrite_H, 8'h02);
    chk("abandon fd", FillData, 16'h5A5A);
    chk("abandon ack w", CpuAck_H, 0);
    tick;
    chk("abandon idle", Busy_H, 0);
    chk("abandon ack", CpuAck_H, 0);
    chk("abandon ww once", WayWrite_H, 0);

`ifdef CACHE_TIMEOUT_EN
    CpuReq_H = 1; ValidHit_H = 0;
    tick; tick;
    n = 0; way = 0;
    for (int i = 0; i < 40 && MemReq_H; i++) begin
      n++;
      tick;
      way |= WayWrite_H;
    end
    chk("timeout fill cycles", n, 16);
    chk("timeout buserr", BusErr_H, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      way |= WayWrite_H;
      chk("timeout buserr held", BusErr_H, 1);
    end
    chk("timeout no ww", way, 0);
    CpuReq_H = 0;
    tick;
    chk("timeout buserr clr", BusErr_H, 0);
    chk("timeout idle", Busy_H, 0);
    miss(8'h04, "post-timeout");
`else
    CpuReq_H = 1; ValidHit_H = 0;
    tick; tick;
    repeat (1000) tick;
    chk("no timeout mreq", MemReq_H, 1);
    chk("no timeout buserr", BusErr_H, 0);
    do_reset;
    miss(8'h01, "post-wait");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
